tracker_axis_sequencer: RTL
===========================

Name: tracker_axis_sequencer

Overview:
- Parametrised successor to the two-axis solar-tracker motor controller.
- Drives theta (vertical) and phi (horizontal) motors one axis at a time.
- Automatic mode balances photoresistor pairs; manual mode servoes to commanded angles, taking the shortest path on phi.
- Adds signed-safe error maths, a settle dwell, direction-reversal dead-time, per-move timeout with a latched fault, and alignment status.
- Sits between the ADC/encoder front end and the H-bridge drivers.

Parameters:
W, 16, width of all sensor and angle inputs
DEADBAND, 5, allowed |error| counted as on target
FULL_TURN, 360, phi units per revolution; HALF = FULL_TURN/2
SETTLE_CYC, 1000, cycles of stillness required before switching axis
REV_GAP, 16, cycles both outputs of an axis are held low before reversing direction
TIMEOUT_CYC, 1000000, maximum cycles spent in one MOVE state before fault

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
sma  in  1  mode select: 0 = automatic, 1 = manual
r_v1, r_v2  in  W  vertical photoresistor pair
r_h1, r_h2  in  W  horizontal photoresistor pair
theta_manual, theta_actual  in  W  theta command and feedback
phi_manual, phi_actual  in  W  phi command and feedback, range 0..FULL_TURN-1
fault_clr  in  1  synchronous fault clear
theta_pos, theta_neg, phi_pos, phi_neg  out  1  registered motor drive enables
busy  out  1  an axis is driving or in its reversal gap
aligned  out  1  both axes settled since their last drive
fault  out  1  move timeout latched

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: all drive outputs, busy, aligned and fault = 0; state = INIT; all counters = 0; stored drive direction = none.
- Output timing: all outputs registered; an input change affects outputs on the next clk edge.
- Error terms: computed in W+1-bit signed arithmetic, so there is no unsigned wrap.
  - Auto theta: e = r_v1 - r_v2. Auto phi: e = r_h1 - r_h2.
  - Manual theta: e = theta_actual - theta_manual. Manual phi: e = phi_actual - phi_manual.
  - In band when |e| <= DEADBAND.
- Direction rule: e > 0 drives pos; e < 0 drives neg.
  - Exception, manual phi only: if |e| > HALF the direction is inverted (shortest path).
  - |e| == HALF uses the direct direction.
- States: INIT, T_MOVE, T_SETTLE, P_MOVE, P_SETTLE, FAULT.
  - INIT goes next cycle to the first MOVE of the mode: auto starts at T_MOVE, manual starts at P_MOVE.
- Auto sequence: T_MOVE -> T_SETTLE -> P_MOVE -> P_SETTLE -> T_MOVE.
- Manual sequence: P_MOVE -> P_SETTLE -> T_MOVE -> T_SETTLE -> P_MOVE.
- MOVE state:
  - Drives only the active axis; the other axis outputs are 0.
  - When in band: outputs 0, enter SETTLE, clear the settle counter.
  - The timeout counter increments every MOVE cycle and clears on leaving MOVE. Reaching TIMEOUT_CYC enters FAULT.
- Reversal: when the requested direction is opposite to the stored one, both outputs of the axis stay 0 for REV_GAP cycles, then the new direction drives.
  - The timeout counter keeps running during the gap.
  - The stored direction resets to none on entering SETTLE.
- SETTLE state:
  - All outputs 0.
  - If |e| > 2*DEADBAND (hysteresis), return to the same axis MOVE.
  - Otherwise, after SETTLE_CYC cycles, set that axis's aligned flag and enter the other axis MOVE.
- Aligned flags: an axis flag clears on any cycle its axis drives. aligned = theta flag AND phi flag.
- Mode change: sma is registered and an edge is detected.
  - On a change, outputs go to 0 that cycle.
  - Counters, flags and stored directions clear.
  - Next state is the first MOVE of the new mode.
  - A mode change is ignored while in FAULT.
- FAULT state: all drives 0, fault = 1. On fault_clr = 1: fault = 0, go to the first MOVE of the current mode.
- rst mid-move: outputs drop asynchronously to 0.
- Invariants:
  - pos and neg of one axis are never both 1.
  - Theta and phi are never driven in the same cycle.

Test Plan:
(Run with SETTLE_CYC=8, REV_GAP=4, TIMEOUT_CYC=64.)
1. Auto, r_v1=600, r_v2=500 -> theta_pos=1 from cycle 2. Set r_v2=598 -> T_SETTLE; 8 cycles later phi drives from the r_h pair.
2. Manual, phi_actual=350, phi_manual=10 (e=340 > 180) -> phi_neg=1. phi_manual=100, phi_actual=280 (e=180) -> phi_pos=1.
3. Auto theta driving pos; swap r_v1/r_v2 -> theta outputs 0 for 4 cycles, then theta_neg=1; timeout unaffected by the swap.
4. Manual with theta_actual held 0, theta_manual=200 -> fault=1 after 64 MOVE cycles with all drives 0. fault_clr pulse -> fault=0, phi MOVE resumes.
5. Both axes in band -> aligned=1 after two settles. Disturb r_h1 by 20 -> phi drives, aligned=0.
6. Toggle sma while theta driving -> drives 0 next cycle, new mode's first MOVE follows. Assert rst mid-drive -> outputs 0 without waiting for a clk edge.

Source files
------------

// File: rtl/tracker_axis_sequencer.sv
// Two-axis solar tracker sequencer: drives the theta and phi H-bridge enables one axis at a time,
// with settle dwell, direction-reversal dead-time, per-move timeout fault and alignment status.
module tracker_axis_sequencer #(
    parameter int W           = 16,
    parameter int DEADBAND    = 5,
    parameter int FULL_TURN   = 360,
    parameter int SETTLE_CYC  = 1000,
    parameter int REV_GAP     = 16,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sma,
    input  logic [W-1:0] r_v1,
    input  logic [W-1:0] r_v2,
    input  logic [W-1:0] r_h1,
    input  logic [W-1:0] r_h2,
    input  logic [W-1:0] theta_manual,
    input  logic [W-1:0] theta_actual,
    input  logic [W-1:0] phi_manual,
    input  logic [W-1:0] phi_actual,
    input  logic         fault_clr,
    output logic         theta_pos,
    output logic         theta_neg,
    output logic         phi_pos,
    output logic         phi_neg,
    output logic         busy,
    output logic         aligned,
    output logic         fault
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int GW = $clog2(REV_GAP + 2);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GAP_LEN     = GW'(REV_GAP);
    localparam logic [W:0]    DB_L        = (W+1)'(DEADBAND);
    localparam logic [W:0]    DB2_L       = (W+1)'(2 * DEADBAND);
    localparam logic [W:0]    HALF_L      = (W+1)'(FULL_TURN / 2);

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_POS  = 2'b01;
    localparam logic [1:0] DIR_NEG  = 2'b10;

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_T_MOVE   = 3'd1,
        S_T_SETTLE = 3'd2,
        S_P_MOVE   = 3'd3,
        S_P_SETTLE = 3'd4,
        S_FAULT    = 3'd5
    } state_t;

    // Inputs are zero-extended by one bit so the difference is a true signed value.
    function automatic logic [W:0] diff_f(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    function automatic logic [W:0] mag_f(input logic [W:0] e);
        return e[W] ? (~e + (W+1)'(1)) : e;
    endfunction

    state_t        state_q, state_d;
    logic          sma_q, sma_d;
    logic [1:0]    dir_q, dir_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          t_al_q, t_al_d;
    logic          p_al_q, p_al_d;
    logic          fault_q, fault_d;
    logic          theta_pos_q, theta_pos_d;
    logic          theta_neg_q, theta_neg_d;
    logic          phi_pos_q, phi_pos_d;
    logic          phi_neg_q, phi_neg_d;
    logic          busy_q, busy_d;
    logic          aligned_q, aligned_d;

    logic          phi_axis_s;
    logic [W:0]    err_t_s, err_p_s, err_s, mag_s;
    logic          in_band_s, out_hyst_s, req_pos_s, rev_wait_s;
    logic          tmo_hit_s, settle_done_s, mode_flip_s;
    logic [1:0]    req_dir_s;
    state_t        first_move_s;

    assign sma_d         = sma;
    assign mode_flip_s   = (sma != sma_q) && (state_q != S_FAULT);
    assign first_move_s  = sma ? S_P_MOVE : S_T_MOVE;
    assign phi_axis_s    = (state_q == S_P_MOVE) || (state_q == S_P_SETTLE);
    assign err_t_s       = sma_q ? diff_f(theta_actual, theta_manual) : diff_f(r_v1, r_v2);
    assign err_p_s       = sma_q ? diff_f(phi_actual, phi_manual) : diff_f(r_h1, r_h2);
    assign err_s         = phi_axis_s ? err_p_s : err_t_s;
    assign mag_s         = mag_f(err_s);
    assign in_band_s     = (mag_s <= DB_L);
    assign out_hyst_s    = (mag_s > DB2_L);
    // Manual phi wraps at FULL_TURN, so more than half a turn is shorter the other way round.
    assign req_pos_s     = ~err_s[W] ^ (phi_axis_s & sma_q & (mag_s > HALF_L));
    assign req_dir_s     = req_pos_s ? DIR_POS : DIR_NEG;
    assign rev_wait_s    = (dir_q != DIR_NONE) && (dir_q != req_dir_s) && (gap_q < GAP_LEN);
    assign tmo_hit_s     = (tmo_q >= TMO_LAST);
    assign settle_done_s = (settle_q >= SETTLE_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        if (mode_flip_s) begin
            state_d = first_move_s;
        end else begin
            case (state_q)
                S_INIT: state_d = first_move_s;
                S_T_MOVE: begin
                    if (in_band_s)      state_d = S_T_SETTLE;
                    else if (tmo_hit_s) state_d = S_FAULT;
                    else                state_d = S_T_MOVE;
                end
                S_T_SETTLE: begin
                    if (out_hyst_s)         state_d = S_T_MOVE;
                    else if (settle_done_s) state_d = S_P_MOVE;
                    else                    state_d = S_T_SETTLE;
                end
                S_P_MOVE: begin
                    if (in_band_s)      state_d = S_P_SETTLE;
                    else if (tmo_hit_s) state_d = S_FAULT;
                    else                state_d = S_P_MOVE;
                end
                S_P_SETTLE: begin
                    if (out_hyst_s)         state_d = S_P_MOVE;
                    else if (settle_done_s) state_d = S_T_MOVE;
                    else                    state_d = S_P_SETTLE;
                end
                S_FAULT: begin
                    if (fault_clr) state_d = first_move_s;
                    else           state_d = S_FAULT;
                end
                default: state_d = S_INIT;
            endcase
        end
    end

    // Drive outputs, counters, stored direction and status flags.
    always_comb begin
        theta_pos_d = 1'b0;
        theta_neg_d = 1'b0;
        phi_pos_d   = 1'b0;
        phi_neg_d   = 1'b0;
        busy_d      = 1'b0;
        dir_d       = DIR_NONE;
        gap_d       = '0;
        settle_d    = '0;
        tmo_d       = '0;
        t_al_d      = t_al_q;
        p_al_d      = p_al_q;
        fault_d     = fault_q;
        if (mode_flip_s) begin
            t_al_d = 1'b0;
            p_al_d = 1'b0;
        end else begin
            case (state_q)
                S_T_MOVE, S_P_MOVE: begin
                    if (state_d == state_q) begin
                        tmo_d  = tmo_q + TW'(1);
                        busy_d = 1'b1;
                        if (rev_wait_s) begin
                            gap_d = gap_q + GW'(1);
                            dir_d = dir_q;
                        end else if (phi_axis_s) begin
                            dir_d     = req_dir_s;
                            phi_pos_d = req_pos_s;
                            phi_neg_d = ~req_pos_s;
                            p_al_d    = 1'b0;
                        end else begin
                            dir_d       = req_dir_s;
                            theta_pos_d = req_pos_s;
                            theta_neg_d = ~req_pos_s;
                            t_al_d      = 1'b0;
                        end
                    end else if (state_d == S_FAULT) begin
                        fault_d = 1'b1;
                    end else begin
                        fault_d = fault_q;
                    end
                end
                S_T_SETTLE, S_P_SETTLE: begin
                    if (state_d == state_q) begin
                        settle_d = settle_q + SW'(1);
                    end else if (!out_hyst_s && phi_axis_s) begin
                        p_al_d = 1'b1;
                    end else if (!out_hyst_s) begin
                        t_al_d = 1'b1;
                    end else begin
                        settle_d = '0;
                    end
                end
                S_FAULT: fault_d = ~fault_clr;
                default: fault_d = fault_q;
            endcase
        end
        aligned_d = t_al_d & p_al_d;
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sma_q       <= 1'b0;
            dir_q       <= DIR_NONE;
            gap_q       <= '0;
            settle_q    <= '0;
            tmo_q       <= '0;
            t_al_q      <= 1'b0;
            p_al_q      <= 1'b0;
            fault_q     <= 1'b0;
            theta_pos_q <= 1'b0;
            theta_neg_q <= 1'b0;
            phi_pos_q   <= 1'b0;
            phi_neg_q   <= 1'b0;
            busy_q      <= 1'b0;
            aligned_q   <= 1'b0;
        end else begin
            sma_q       <= sma_d;
            dir_q       <= dir_d;
            gap_q       <= gap_d;
            settle_q    <= settle_d;
            tmo_q       <= tmo_d;
            t_al_q      <= t_al_d;
            p_al_q      <= p_al_d;
            fault_q     <= fault_d;
            theta_pos_q <= theta_pos_d;
            theta_neg_q <= theta_neg_d;
            phi_pos_q   <= phi_pos_d;
            phi_neg_q   <= phi_neg_d;
            busy_q      <= busy_d;
            aligned_q   <= aligned_d;
        end
    end

    assign theta_pos = theta_pos_q;
    assign theta_neg = theta_neg_q;
    assign phi_pos   = phi_pos_q;
    assign phi_neg   = phi_neg_q;
    assign busy      = busy_q;
    assign aligned   = aligned_q;
    assign fault     = fault_q;

endmodule
